// File: rtl/zoom_pkg.sv
`default_nettype none
// zoom_pkg: center limits and defaults, arithmetic width, scheduler states and pan button bit positions.
package zoom_pkg;

  localparam int CX_DEFAULT = 960;
  localparam int CY_DEFAULT = 540;
  localparam int CX_MIN     = 320;
  localparam int CX_MAX     = 1600;
  localparam int CY_MIN     = 180;
  localparam int CY_MAX     = 900;

  // Signed width used for all center arithmetic before saturation.
  localparam int CW = 13;

  localparam int PAN_UP    = 3;
  localparam int PAN_DOWN  = 2;
  localparam int PAN_LEFT  = 1;
  localparam int PAN_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2,
    UPDATE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/zoom_center_clamp.sv
`default_nettype none
// zoom_center_clamp: moves one center axis by +/-step and saturates the result to [MIN,MAX].
module zoom_center_clamp
  import zoom_pkg::*;
#(
  parameter int W   = 12,
  parameter int MIN = 0,
  parameter int MAX = 4095
) (
  input  logic [W-1:0]  cur_i,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic [CW-1:0] step_i,
  output logic [W-1:0]  next_o
);

  localparam logic signed [CW-1:0] MIN_S = CW'(MIN);
  localparam logic signed [CW-1:0] MAX_S = CW'(MAX);

  logic signed [CW-1:0] cur_s;
  logic signed [CW-1:0] sum_s;
  logic signed [CW-1:0] sat_s;

  always_comb begin
    cur_s = signed'({{(CW-W){1'b0}}, cur_i});
    sum_s = cur_s;
    // Both directions pressed cancel out.
    if (inc_i && !dec_i) begin
      sum_s = cur_s + signed'(step_i);
    end else if (dec_i && !inc_i) begin
      sum_s = cur_s - signed'(step_i);
    end
    sat_s = sum_s;
    if (sum_s < MIN_S) begin
      sat_s = MIN_S;
    end else if (sum_s > MAX_S) begin
      sat_s = MAX_S;
    end
    next_o = W'(sat_s);
  end

endmodule
`default_nettype wire

// File: rtl/zoom_frame_scheduler.sv
`default_nettype none
// zoom_frame_scheduler: paces one address frame per display sync and pans/recenters the zoom center.
// Optional ZOOM_PAN_ACCEL_EN: doubles the pan step while the same buttons stay held, capped at MAX_STEP.
module zoom_frame_scheduler
  import zoom_pkg::*;
#(
  parameter int PAN_STEP = 4,
  parameter int MAX_STEP = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic        sync_in,
  input  logic [3:0]  pan_in,
  input  logic        recenter_in,
  input  logic        addr_ready_in,
  input  logic        gen_tlast_in,
  output logic        addr_valid_out,
  output logic        incr_out,
  output logic [11:0] center_x_out,
  output logic [10:0] center_y_out,
  output logic        frame_done_out,
  output logic        overrun_out
);

  localparam logic [CW-1:0] STEP_INIT = CW'(PAN_STEP);

  state_t        state_q;
  logic          valid_q;
  logic          done_q;
  logic          overrun_q;
  logic          recenter_q;
  logic [11:0]   cx_q;
  logic [11:0]   cx_d;
  logic [11:0]   cx_next;
  logic [10:0]   cy_q;
  logic [10:0]   cy_d;
  logic [10:0]   cy_next;
  logic [CW-1:0] step_q;
  logic [CW-1:0] step_d;
  logic          recenter_any;

`ifdef ZOOM_PAN_ACCEL_EN
  localparam logic [CW:0] STEP_CAP = (CW+1)'(MAX_STEP);
  logic [3:0]  prev_pan_q;
  logic [CW:0] step_dbl;

  always_comb begin
    step_dbl = {step_q, 1'b0};
    if ((pan_in != 4'b0000) && (pan_in == prev_pan_q)) begin
      step_d = (step_dbl > STEP_CAP) ? STEP_CAP[CW-1:0] : step_dbl[CW-1:0];
    end else begin
      step_d = STEP_INIT;
    end
  end
`else
  always_comb begin
    step_d = step_q;
  end
`endif

  zoom_center_clamp #(
    .W   (12),
    .MIN (CX_MIN),
    .MAX (CX_MAX)
  ) u_clamp_x (
    .cur_i  (cx_q),
    .inc_i  (pan_in[PAN_RIGHT]),
    .dec_i  (pan_in[PAN_LEFT]),
    .step_i (step_d),
    .next_o (cx_next)
  );

  zoom_center_clamp #(
    .W   (11),
    .MIN (CY_MIN),
    .MAX (CY_MAX)
  ) u_clamp_y (
    .cur_i  (cy_q),
    .inc_i  (pan_in[PAN_DOWN]),
    .dec_i  (pan_in[PAN_UP]),
    .step_i (step_d),
    .next_o (cy_next)
  );

  // A recenter arriving in the UPDATE cycle itself still wins.
  always_comb begin
    recenter_any = recenter_q | recenter_in;
    cx_d = recenter_any ? 12'(CX_DEFAULT) : cx_next;
    cy_d = recenter_any ? 11'(CY_DEFAULT) : cy_next;
  end

  assign incr_out       = valid_q & addr_ready_in;
  assign addr_valid_out = valid_q;
  assign frame_done_out = done_q;
  assign overrun_out    = overrun_q;
  assign center_x_out   = cx_q;
  assign center_y_out   = cy_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      recenter_q <= 1'b0;
      cx_q       <= 12'(CX_DEFAULT);
      cy_q       <= 11'(CY_DEFAULT);
      step_q     <= STEP_INIT;
`ifdef ZOOM_PAN_ACCEL_EN
      prev_pan_q <= 4'b0000;
`endif
    end else begin
      done_q <= 1'b0;
      if (recenter_in) begin
        recenter_q <= 1'b1;
      end
      if (sync_in && ((state_q == RUN) || (state_q == UPDATE))) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (enable_in) begin
            state_q <= WAIT_SYNC;
          end
        end
        WAIT_SYNC: begin
          if (sync_in) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // Valid rises one cycle into RUN, then stays up until the last handshake.
          if (incr_out && gen_tlast_in) begin
            state_q <= UPDATE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            valid_q <= 1'b1;
          end
        end
        UPDATE: begin
          cx_q       <= cx_d;
          cy_q       <= cy_d;
          step_q     <= step_d;
          recenter_q <= 1'b0;
`ifdef ZOOM_PAN_ACCEL_EN
          prev_pan_q <= pan_in;
`endif
          state_q    <= enable_in ? WAIT_SYNC : IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zoom_frame_scheduler.sv
`default_nettype none
// tb_zoom_frame_scheduler: directed frames plus random stimulus, checked every cycle against a frame-level model.
module tb_zoom_frame_scheduler;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_RUN  = 2;
  localparam int P_UPD  = 3;
  localparam int STEP0  = 4;
  localparam int STEPMX = 64;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        enable_in = 1'b0;
  logic        sync_in = 1'b0;
  logic [3:0]  pan_in = 4'b0000;
  logic        recenter_in = 1'b0;
  logic        addr_ready_in = 1'b0;
  logic        gen_tlast_in = 1'b0;
  logic        addr_valid_out;
  logic        incr_out;
  logic [11:0] center_x_out;
  logic [10:0] center_y_out;
  logic        frame_done_out;
  logic        overrun_out;

  always #5 clk_in = ~clk_in;

  zoom_frame_scheduler dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .enable_in      (enable_in),
    .sync_in        (sync_in),
    .pan_in         (pan_in),
    .recenter_in    (recenter_in),
    .addr_ready_in  (addr_ready_in),
    .gen_tlast_in   (gen_tlast_in),
    .addr_valid_out (addr_valid_out),
    .incr_out       (incr_out),
    .center_x_out   (center_x_out),
    .center_y_out   (center_y_out),
    .frame_done_out (frame_done_out),
    .overrun_out    (overrun_out)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Frame-level model: phase, cycles spent in RUN, center and sticky flags.
  int       m_phase = P_IDLE;
  int       m_age = 0;
  int       m_cx = 960;
  int       m_cy = 540;
  int       m_step = STEP0;
  bit       m_over = 1'b0;
  bit       m_rc = 1'b0;
  logic [3:0] m_prev = 4'b0000;

  bit last_incr = 1'b0;
  bit last_done = 1'b0;
  bit use_gen = 1'b0;
  int cnt = 0;
  int n_addr = 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_step();
    bit exp_valid;
    int dx;
    int dy;
    exp_valid = (m_phase == P_RUN) && (m_age >= 1);
    if (rst_in) begin
      m_phase = P_IDLE; m_age = 0; m_cx = 960; m_cy = 540; m_step = STEP0;
      m_over = 1'b0; m_rc = 1'b0; m_prev = 4'b0000;
      return;
    end
    if (recenter_in) m_rc = 1'b1;
    if (sync_in && (m_phase == P_RUN || m_phase == P_UPD)) m_over = 1'b1;
    case (m_phase)
      P_IDLE: if (enable_in) m_phase = P_WAIT;
      P_WAIT: if (sync_in) begin m_phase = P_RUN; m_age = 0; end
      P_RUN: begin
        if (exp_valid && addr_ready_in && gen_tlast_in) m_phase = P_UPD;
        else m_age++;
      end
      default: begin
`ifdef ZOOM_PAN_ACCEL_EN
        if (pan_in != 4'b0000 && pan_in == m_prev) m_step = (m_step * 2 > STEPMX) ? STEPMX : m_step * 2;
        else m_step = STEP0;
        m_prev = pan_in;
`endif
        dx = int'(pan_in[0]) - int'(pan_in[1]);
        dy = int'(pan_in[2]) - int'(pan_in[3]);
        if (m_rc) begin
          m_cx = 960; m_cy = 540;
        end else begin
          m_cx = clampi(m_cx + dx * m_step, 320, 1600);
          m_cy = clampi(m_cy + dy * m_step, 180, 900);
        end
        m_rc = 1'b0;
        m_phase = enable_in ? P_WAIT : P_IDLE;
      end
    endcase
  endtask

  // One cycle: compare outputs mid-cycle, advance the model, then step past the next edge.
  task automatic tick();
    bit ev;
    @(negedge clk_in);
    ev = (m_phase == P_RUN) && (m_age >= 1);
    check("addr_valid", int'(addr_valid_out), int'(ev));
    check("incr", int'(incr_out), int'(ev && addr_ready_in));
    check("frame_done", int'(frame_done_out), int'(m_phase == P_UPD));
    check("overrun", int'(overrun_out), int'(m_over));
    check("center_x", int'(center_x_out), m_cx);
    check("center_y", int'(center_y_out), m_cy);
    last_incr = incr_out;
    last_done = frame_done_out;
    model_step();
    @(posedge clk_in);
    #1;
    if (use_gen) begin
      if (last_incr && !rst_in) cnt++;
      gen_tlast_in = (cnt == n_addr - 1);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cnt = 0;
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame(input int n, input logic [3:0] pan, input int rc_at, input int sync_at,
                       input bit rnd, output int incs, output int first_k);
    int k;
    pan_in = pan;
    n_addr = n;
    cnt = 0;
    use_gen = 1'b1;
    gen_tlast_in = (n == 1);
    incs = 0;
    first_k = -1;
    k = 0;
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    while (k < 400 && !last_done) begin
      k++;
      recenter_in = (k == rc_at);
      sync_in = (k == sync_at);
      addr_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (last_incr) begin
        incs++;
        if (first_k < 0) first_k = k;
      end
    end
    recenter_in = 1'b0;
    sync_in = 1'b0;
    check("frame_done_seen", int'(last_done), 1);
  endtask

  initial begin
    int incs;
    int fk;
    enable_in = 1'b1;
    addr_ready_in = 1'b1;
    do_reset();
    check("rst_center_x", int'(center_x_out), 960);
    check("rst_center_y", int'(center_y_out), 540);
    check("rst_valid", int'(addr_valid_out), 0);
    check("rst_overrun", int'(overrun_out), 0);
    check("rst_done", int'(frame_done_out), 0);

    frame(1, 4'b0000, -1, -1, 1'b0, incs, fk);
    check("first_incr_latency", fk, 2);
    check("idle_frame_cx", int'(center_x_out), 960);
    check("idle_frame_cy", int'(center_y_out), 540);

    frame(8, 4'b0000, -1, -1, 1'b1, incs, fk);
    check("incr_count_8", incs, 8);
    tick();
    check("done_single_pulse", int'(last_done), 0);

    frame(1, 4'b0010, -1, -1, 1'b0, incs, fk);
    check("pan_left_cx", int'(center_x_out), 956);
    frame(8, 4'b0010, 3, -1, 1'b0, incs, fk);
    check("recenter_cx", int'(center_x_out), 960);
    check("recenter_cy", int'(center_y_out), 540);

    check("overrun_before", int'(overrun_out), 0);
    frame(8, 4'b0000, -1, 3, 1'b0, incs, fk);
    check("overrun_set", int'(overrun_out), 1);
    frame(1, 4'b0000, -1, -1, 1'b1, incs, fk);
    check("overrun_sticky", int'(overrun_out), 1);
    do_reset();
    check("overrun_cleared", int'(overrun_out), 0);

    for (int i = 0; i < 6; i++) frame(1, 4'b0001, -1, -1, 1'b0, incs, fk);
`ifdef ZOOM_PAN_ACCEL_EN
    check("accel_6_frames_cx", int'(center_x_out), 1148);
`else
    check("const_6_frames_cx", int'(center_x_out), 984);
`endif
    for (int i = 0; i < 170; i++) frame(1, 4'b0001, -1, -1, 1'b0, incs, fk);
    check("sat_cx", int'(center_x_out), 1600);
    frame(1, 4'b0001, -1, -1, 1'b1, incs, fk);
    check("sat_cx_hold", int'(center_x_out), 1600);
    frame(1, 4'b1000, -1, -1, 1'b0, incs, fk);
    check("pan_up_cy", int'(center_y_out), 536);
    frame(1, 4'b1100, -1, -1, 1'b0, incs, fk);
    check("up_down_cy", int'(center_y_out), 536);

    use_gen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst_in        = ($urandom_range(0, 299) == 0);
      enable_in     = ($urandom_range(0, 9) < 8);
      sync_in       = ($urandom_range(0, 9) == 0);
      pan_in        = 4'($urandom);
      recenter_in   = ($urandom_range(0, 19) == 0);
      addr_ready_in = 1'($urandom_range(0, 1));
      gen_tlast_in  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zoom_frame_scheduler.md
ZOOM_FRAME_SCHEDULER -- requirements
Module: zoom_frame_scheduler

Interface
REQ-001 SHALL have parameter PAN_STEP, default 4, center change in pixels per frame per axis.
REQ-002 SHALL have parameter MAX_STEP, default 64, step ceiling when acceleration is compiled in.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable_in  input  1  run frames when high; sampled only at frame boundaries.
REQ-006 SHALL have port sync_in  input  1  one-cycle display frame-start pulse.
REQ-007 SHALL have port pan_in  input  4  held buttons {up,down,left,right}, bit 3 = up.
REQ-008 SHALL have port recenter_in  input  1  request to return to the default center.
REQ-009 SHALL have port addr_ready_in  input  1  downstream read-command FIFO can accept.
REQ-010 SHALL have port gen_tlast_in  input  1  last-address flag from the address generator.
REQ-011 SHALL have port addr_valid_out  output  1  current generator address is valid downstream.
REQ-012 SHALL have port incr_out  output  1  advance pulse to the address generator.
REQ-013 SHALL have port center_x_out  output  12  zoom center X to the generator.
REQ-014 SHALL have port center_y_out  output  11  zoom center Y to the generator.
REQ-015 SHALL have port frame_done_out  output  1  one-cycle pulse at the end of each frame.
REQ-016 SHALL have port overrun_out  output  1  sticky flag: sync_in arrived while a frame was in flight.

Function
REQ-017 SHALL implement states IDLE, WAIT_SYNC, RUN, UPDATE.
REQ-018 SHALL transition IDLE->WAIT_SYNC on enable_in=1 (one-cycle latency).
REQ-019 SHALL transition WAIT_SYNC->RUN on sync_in=1.
REQ-020 SHALL transition RUN->UPDATE on a handshake (incr_out=1) with gen_tlast_in=1.
REQ-021 SHALL transition UPDATE->WAIT_SYNC if enable_in=1, else UPDATE->IDLE.
REQ-022 SHALL drive addr_valid_out=1 only in RUN.
REQ-023 SHALL drive incr_out = addr_valid_out AND addr_ready_in, combinationally, with no bubble between consecutive handshakes.
REQ-024 SHALL ignore enable_in deassertion in RUN; the frame completes.
REQ-025 SHALL hold center_x_out and center_y_out constant outside UPDATE; new values are visible the cycle after UPDATE.
REQ-026 SHALL pulse frame_done_out high for exactly the UPDATE cycle.
REQ-027 SHALL compute the new center in UPDATE from pan_in sampled in that cycle:
- up decreases Y by step; down increases Y; left decreases X; right increases X.
- opposing bits both set: no change on that axis.
REQ-028 SHALL give recenter_in priority over pan_in; recenter_in pulses are captured (sticky) until the next UPDATE, then cleared.
REQ-029 SHALL do center arithmetic at 13 bits signed and saturate to X in [CX_MIN,CX_MAX], Y in [CY_MIN,CY_MAX]; no wrap-around.
REQ-030 SHALL set overrun_out on sync_in=1 during RUN or UPDATE; sync_in is otherwise ignored outside WAIT_SYNC.

Reset
REQ-031 SHALL, on rst_in=1, force state=IDLE, incr_out=0, addr_valid_out=0, frame_done_out=0, overrun_out=0, center=(CX_DEFAULT,CY_DEFAULT), recenter capture=0, step=PAN_STEP.
REQ-032 SHALL abandon any in-flight frame on reset mid-RUN; the address generator shares rst_in.

Configuration
REQ-033 SHALL, with ZOOM_PAN_ACCEL_EN defined, double step each UPDATE in which the same nonzero pan_in is held as at the previous UPDATE, capped at MAX_STEP, and restore PAN_STEP on any change.
REQ-034 SHALL, without ZOOM_PAN_ACCEL_EN, use a constant step of PAN_STEP.

Structure
REQ-035 SHALL take from shared package zoom_pkg: CX_DEFAULT=960, CY_DEFAULT=540, CX_MIN=320, CX_MAX=1600, CY_MIN=180, CY_MAX=900, state enum, pan bit indices.
REQ-036 SHALL place saturating center update in one sub-module, zoom_center_clamp, instanced once per axis.

Verification
REQ-037 SHALL cover: reset, enable=1, sync pulse, ready=1 -> first incr 2 cycles after sync, center stays (960,540).
REQ-038 SHALL cover: ready toggled 50% over 8-address frame with tlast on 8th -> exactly 8 incr pulses, 1 frame_done.
REQ-039 SHALL cover: pan_in=right at UPDATE, center_x=1598 -> center_x=1600 (saturated); pan_in=up+down -> Y unchanged.
REQ-040 SHALL cover: recenter pulse mid-RUN with pan_in=left held -> after UPDATE center=(960,540).
REQ-041 SHALL cover: sync_in during RUN -> overrun_out=1 and stays 1 until rst_in.
REQ-042 SHALL cover, with ZOOM_PAN_ACCEL_EN: right held 6 frames from x=960 -> steps 4,8,16,32,64,64; x=1148.
